// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port ids and direction codes for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic PORT_I   = 1'b0;
    localparam logic PORT_D   = 1'b1;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports and shared-memory bus of the memory arbiter
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_address;
    logic [1:0]  i_access_size;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_address;
    logic [31:0] d_data_in;
    logic        d_rw;
    logic [1:0]  d_access_size;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] m_address;
    logic [31:0] m_data_in;
    logic [1:0]  m_access_size;
    logic        m_rw;
    logic        m_enable;
    logic [31:0] m_data_out;
    modport slave (
        input  i_req, i_address, i_access_size, d_req, d_address, d_data_in, d_rw, d_access_size, m_data_out,
        output i_done, i_rdata, d_done, d_rdata, m_address, m_data_in, m_access_size, m_rw, m_enable
    );
    modport master (
        output i_req, i_address, i_access_size, d_req, d_address, d_data_in, d_rw, d_access_size, m_data_out,
        input  i_done, i_rdata, d_done, d_rdata, m_address, m_data_in, m_access_size, m_rw, m_enable
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARBITER_RR_EN makes ties go to the port not granted last
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARBITER_RR_EN
    input  logic last,
`endif
    output logic win
);
`ifdef MEM_ARBITER_RR_EN
    always_comb win = (i_req && d_req) ? ~last : ((d_req || !i_req) ? PORT_D : PORT_I);
`else
    always_comb win = (d_req || !i_req) ? PORT_D : PORT_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: instruction/data arbiter for one shared memory, one access in flight at a time
// Define MEM_ARBITER_RR_EN for round-robin tie resolution instead of data-first priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input logic          clock,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        win, pick_win, rw_r, grant;
    logic [31:0] addr_r, wdata_r, i_rdata_r, d_rdata_r;
    logic [1:0]  size_r;
    assign grant = (state == IDLE) && (bus.i_req || bus.d_req);
`ifdef MEM_ARBITER_RR_EN
    logic last;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) last <= PORT_I;
        else if (grant) last <= pick_win;
    mem_arb_pick u_pick (.i_req(bus.i_req), .d_req(bus.d_req), .last(last), .win(pick_win));
`else
    mem_arb_pick u_pick (.i_req(bus.i_req), .d_req(bus.d_req), .win(pick_win));
`endif
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx     = state;
        bus.m_enable = 1'b0;
        bus.m_rw     = RW_READ;
        bus.i_done   = 1'b0;
        bus.d_done   = 1'b0;
        unique case (state)
            IDLE: state_nx = grant ? BUSY : IDLE;
            BUSY: begin
                state_nx     = (cnt == 4'd1) ? RESP : BUSY;
                bus.m_enable = 1'b1;
                bus.m_rw     = rw_r;
            end
            RESP: begin
                state_nx   = IDLE;
                bus.i_done = (win == PORT_I);
                bus.d_done = (win == PORT_D);
            end
            default: state_nx = IDLE;
        endcase
    end
    // operands are latched at grant so the memory sees them unchanged for the whole access
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            win       <= PORT_I;
            rw_r      <= RW_READ;
            addr_r    <= '0;
            wdata_r   <= '0;
            size_r    <= '0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else if (grant) begin
            cnt     <= 4'(LATENCY);
            win     <= pick_win;
            addr_r  <= (pick_win == PORT_D) ? bus.d_address : bus.i_address;
            wdata_r <= (pick_win == PORT_D) ? bus.d_data_in : '0;
            rw_r    <= (pick_win == PORT_D) ? bus.d_rw : RW_READ;
            size_r  <= (pick_win == PORT_D) ? bus.d_access_size : bus.i_access_size;
        end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && rw_r == RW_READ) begin
                if (win == PORT_D) d_rdata_r <= bus.m_data_out;
                else i_rdata_r <= bus.m_data_out;
            end
        end
    end
    assign bus.m_address     = addr_r;
    assign bus.m_data_in     = wdata_r;
    assign bus.m_access_size = size_r;
    assign bus.i_rdata       = i_rdata_r;
    assign bus.d_rdata       = d_rdata_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter at LATENCY=2 and LATENCY=1
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    localparam logic [31:0] KEY = 32'ha7bf_fff8;
    typedef struct packed {logic port; logic [31:0] addr; logic [31:0] rdata;} exp_t;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    exp_t e;
    int lat, en, nd;
    logic p, st, rw;
    logic [31:0] rd, a, wd;
    logic [1:0] sz;
    mem_arbiter_if bus ();
    mem_arbiter_if bus2 ();
    always #5 clock = ~clock;
    // memory returns address^KEY only while enabled, so a capture outside BUSY reads junk
    assign bus.m_data_out  = bus.m_enable ? (bus.m_address ^ KEY) : 32'h0bad_f00d;
    assign bus2.m_data_out = bus2.m_enable ? (bus2.m_address ^ KEY) : 32'h0bad_f00d;
    mem_arbiter #(.LATENCY(2)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    mem_arbiter #(.LATENCY(1)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

    task automatic observe();
        lat = -1; en = 0; st = 1'b1; p = 1'b0; rd = '0; a = '0; wd = '0; rw = 1'b1; sz = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (bus.m_enable) begin
                if (en == 0) begin
                    a = bus.m_address; wd = bus.m_data_in; rw = bus.m_rw; sz = bus.m_access_size;
                end else if ({bus.m_address, bus.m_data_in, bus.m_rw, bus.m_access_size} !== {a, wd, rw, sz}) st = 1'b0;
                en++;
            end
            if (bus.i_done || bus.d_done) begin
                lat = c;
                p = bus.d_done;
                rd = bus.d_done ? bus.d_rdata : bus.i_rdata;
                if (bus.d_done) bus.d_req = 1'b0;
                else bus.i_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        {bus.i_req, bus.d_req, bus.d_rw, bus2.i_req, bus2.d_req, bus2.d_rw} = '0;
        {bus.i_address, bus.d_address, bus.d_data_in, bus2.i_address, bus2.d_address, bus2.d_data_in} = '0;
        {bus.i_access_size, bus.d_access_size, bus2.i_access_size, bus2.d_access_size} = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (bus.m_enable !== 1'b0) begin bad++; $display("FAIL reset_m_enable got=%0h want=0", bus.m_enable); end
        total++; if (bus.m_rw !== 1'b1) begin bad++; $display("FAIL reset_m_rw got=%0h want=1", bus.m_rw); end
        total++; if (bus.m_address !== 32'h0) begin bad++; $display("FAIL reset_m_address got=%0h want=0", bus.m_address); end
        total++; if (bus.m_data_in !== 32'h0) begin bad++; $display("FAIL reset_m_data_in got=%0h want=0", bus.m_data_in); end
        total++; if (bus.m_access_size !== 2'h0) begin bad++; $display("FAIL reset_m_size got=%0h want=0", bus.m_access_size); end
        total++; if ({bus.i_done, bus.d_done} !== 2'b00) begin bad++; $display("FAIL reset_done got=%0b want=00", {bus.i_done, bus.d_done}); end
        total++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", {bus.i_rdata, bus.d_rdata}); end
        total++; if (bus2.m_enable !== 1'b0) begin bad++; $display("FAIL reset_m_enable2 got=%0h want=0", bus2.m_enable); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ifetch();
        @(negedge clock);
        bus.i_req = 1'b1; bus.i_address = 32'h8002_0000; bus.i_access_size = 2'd2;
        exp_q.push_back('{PORT_I, 32'h8002_0000, 32'h27bd_fff8});
        observe();
        e = exp_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL ifetch_latency got=%0d want=3", lat); end
        total++; if (en !== 2) begin bad++; $display("FAIL ifetch_enable_cycles got=%0d want=2", en); end
        total++; if ({rw, wd, sz} !== {RW_READ, 32'h0, 2'd2}) begin bad++; $display("FAIL ifetch_operands got=%0h want=%0h", {rw, wd, sz}, {RW_READ, 32'h0, 2'd2}); end
        total++; if ({p, a, rd} !== e) begin bad++; $display("FAIL ifetch_result got=%0h want=%0h", {p, a, rd}, e); end
    endtask

    task automatic test_write();
        @(negedge clock);
        bus.d_req = 1'b1; bus.d_rw = RW_READ; bus.d_address = 32'h1000_0040; bus.d_access_size = 2'd2;
        exp_q.push_back('{PORT_D, 32'h1000_0040, 32'hb7bf_ffb8});
        observe();
        e = exp_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL dread_latency got=%0d want=3", lat); end
        total++; if ({p, a, rd} !== e) begin bad++; $display("FAIL dread_result got=%0h want=%0h", {p, a, rd}, e); end
        @(negedge clock);
        bus.d_req = 1'b1; bus.d_rw = RW_WRITE; bus.d_address = 32'h8002_0100; bus.d_data_in = 32'hdead_beef; bus.d_access_size = 2'd1;
        exp_q.push_back('{PORT_D, 32'h8002_0100, 32'hb7bf_ffb8});
        observe();
        e = exp_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL write_latency got=%0d want=3", lat); end
        total++; if (en !== 2) begin bad++; $display("FAIL write_enable_cycles got=%0d want=2", en); end
        total++; if ({st, rw, wd, sz} !== {1'b1, RW_WRITE, 32'hdead_beef, 2'd1}) begin bad++; $display("FAIL write_operands got=%0h want=%0h", {st, rw, wd, sz}, {1'b1, RW_WRITE, 32'hdead_beef, 2'd1}); end
        total++; if ({p, a, rd} !== e) begin bad++; $display("FAIL write_result got=%0h want=%0h", {p, a, rd}, e); end
        @(negedge clock);
        total++; if ({bus.m_enable, bus.m_rw} !== 2'b01) begin bad++; $display("FAIL idle_en_rw got=%0b want=01", {bus.m_enable, bus.m_rw}); end
        total++; if ({bus.m_address, bus.m_data_in} !== {32'h8002_0100, 32'hdead_beef}) begin bad++; $display("FAIL idle_hold got=%0h want=%0h", {bus.m_address, bus.m_data_in}, {32'h8002_0100, 32'hdead_beef}); end
    endtask

    task automatic test_tie();
        @(negedge clock);
        bus.i_req = 1'b1; bus.i_address = 32'h0040_0000; bus.i_access_size = 2'd2;
        bus.d_req = 1'b1; bus.d_rw = RW_READ; bus.d_address = 32'h1000_0080; bus.d_access_size = 2'd2;
        exp_q.push_back('{PORT_D, 32'h1000_0080, 32'hb7bf_ff78});
`ifdef MEM_ARBITER_RR_EN
        exp_q.push_back('{PORT_I, 32'h0040_0000, 32'ha7ff_fff8});
        exp_q.push_back('{PORT_D, 32'h1000_00c0, 32'hb7bf_ff38});
`else
        exp_q.push_back('{PORT_D, 32'h1000_00c0, 32'hb7bf_ff38});
        exp_q.push_back('{PORT_I, 32'h0040_0000, 32'ha7ff_fff8});
`endif
        for (int k = 0; k < 3; k++) begin
            observe();
            e = exp_q.pop_front();
            total++; if ({p, a, rd} !== e) begin bad++; $display("FAIL tie_grant%0d got=%0h want=%0h", k, {p, a, rd}, e); end
            total++; if (en !== 2) begin bad++; $display("FAIL tie_enable%0d got=%0d want=2", k, en); end
            if (k == 0) begin
                @(negedge clock);
                bus.d_req = 1'b1; bus.d_address = 32'h1000_00c0;
            end
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clock);
        bus.d_req = 1'b1; bus.d_rw = RW_READ; bus.d_address = 32'h1000_0100;
        repeat (2) @(negedge clock);
        total++; if (bus.m_enable !== 1'b1) begin bad++; $display("FAIL rstbusy_pre_enable got=%0h want=1", bus.m_enable); end
        reset_n = 1'b0;
        #1;
        total++; if (bus.m_enable !== 1'b0) begin bad++; $display("FAIL rstbusy_enable got=%0h want=0", bus.m_enable); end
        total++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin bad++; $display("FAIL rstbusy_rdata got=%0h want=0", {bus.i_rdata, bus.d_rdata}); end
        bus.d_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        nd = 0; en = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus.i_done || bus.d_done) nd++;
            if (bus.m_enable) en++;
        end
        total++; if ({nd, en} !== {32'd0, 32'd0}) begin bad++; $display("FAIL rstbusy_quiet done=%0d en=%0d want=0,0", nd, en); end
        @(negedge clock);
        bus.i_req = 1'b1; bus.i_address = 32'h0040_0010;
        exp_q.push_back('{PORT_I, 32'h0040_0010, 32'ha7ff_ffe8});
        observe();
        e = exp_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL rstbusy_after_latency got=%0d want=3", lat); end
        total++; if ({p, a, rd} !== e) begin bad++; $display("FAIL rstbusy_after_result got=%0h want=%0h", {p, a, rd}, e); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        bus2.i_req = 1'b1; bus2.i_address = 32'h0040_0100; bus2.i_access_size = 2'd2;
        exp_q.push_back('{PORT_I, 32'h0040_0100, 32'h0040_0100 ^ KEY});
        for (int k = 0; k < 4; k++) begin
            lat = -1; en = 0; a = '0; rd = '0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clock);
                if (bus2.m_enable) begin en++; a = bus2.m_address; end
                if (bus2.i_done) begin lat = c; rd = bus2.i_rdata; break; end
            end
            e = exp_q.pop_front();
            total++; if (lat !== ((k == 0) ? 2 : 3)) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", k, lat, (k == 0) ? 2 : 3); end
            total++; if (en !== 1) begin bad++; $display("FAIL b2b_enable%0d got=%0d want=1", k, en); end
            total++; if ({a, rd} !== {e.addr, e.rdata}) begin bad++; $display("FAIL b2b_result%0d got=%0h want=%0h", k, {a, rd}, {e.addr, e.rdata}); end
            if (k < 3) begin
                bus2.i_address = 32'h0040_0100 + 32'(4 * (k + 1));
                exp_q.push_back('{PORT_I, bus2.i_address, bus2.i_address ^ KEY});
            end else bus2.i_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_write();
        test_tie();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 2, number of cycles m_enable is held per access; legal range 1..15.
REQ-002 clock  input  1  system clock; all state updates on posedge clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction port request; level, held until i_done.
REQ-005 i_address  input  32  instruction fetch byte address; stable while i_req high.
REQ-006 i_access_size  input  2  instruction access size code, passed to memory unchanged.
REQ-007 i_done  output  1  one-cycle pulse; instruction access complete, i_rdata valid.
REQ-008 i_rdata  output  32  instruction read data.
REQ-009 d_req  input  1  data port request; level, held until d_done.
REQ-010 d_address  input  32  data byte address; stable while d_req high.
REQ-011 d_data_in  input  32  store data.
REQ-012 d_rw  input  1  1 = read, 0 = write.
REQ-013 d_access_size  input  2  data access size code, passed to memory unchanged.
REQ-014 d_done  output  1  one-cycle pulse; data access complete.
REQ-015 d_rdata  output  32  data read result.
REQ-016 m_address  output  32  shared memory address.
REQ-017 m_data_in  output  32  shared memory write data.
REQ-018 m_access_size  output  2  shared memory access size.
REQ-019 m_rw  output  1  shared memory direction, 1 = read, 0 = write.
REQ-020 m_enable  output  1  shared memory enable.
REQ-021 m_data_out  input  32  shared memory read data.

Function
REQ-022 FSM states IDLE, BUSY, RESP; single outstanding access at any time.
REQ-023 IDLE: any req high -> pick winner, register its address/data/rw/size and winner id, load counter = LATENCY, go BUSY; no req -> stay IDLE.
REQ-024 Instruction-port accesses always registered as read (m_rw = 1), m_data_in = 0.
REQ-025 BUSY: m_enable = 1, m_* driven only from registered operands; counter decrements each cycle; at counter = 1, capture m_data_out into the winner's rdata register (reads only) and go RESP.
REQ-026 RESP: winner's done = 1 for exactly this cycle, m_enable = 0; go IDLE unconditionally.
REQ-027 Latency: req sampled in IDLE at edge t0 -> done high in cycle t0 + LATENCY + 1; back-to-back accesses from one port complete every LATENCY + 2 cycles.
REQ-028 Writes: m_enable high for all LATENCY BUSY cycles with identical operands; d_rdata holds its previous value.
REQ-029 Tie in IDLE (both req): data port wins (fixed priority) unless the round-robin option (REQ-034) is enabled.
REQ-030 A requester must drop req on the edge ending its done cycle; req changes during BUSY/RESP are ignored.
REQ-031 Outside BUSY: m_enable = 0, m_rw = 1, m_address/m_data_in/m_access_size hold last registered values.

Reset
REQ-032 reset_n low, asynchronously: state = IDLE, counter = 0, i_done = d_done = 0, i_rdata = d_rdata = 0, m_enable = 0, m_rw = 1, m_address = m_data_in = 0, m_access_size = 0, last-grant = instruction.
REQ-033 Reset asserted during BUSY or RESP abandons the access; no done pulse is produced for it after reset release.

Configuration
REQ-034 MEM_ARBITER_RR_EN defined: ties are resolved round-robin, i.e. granted to the port not granted last; last-grant updates on every grant. Undefined: fixed data-first priority; the last-grant register is not built.

Structure
REQ-035 Package mem_arb_pkg holds: the state encoding (IDLE/BUSY/RESP), port ids PORT_I = 0 and PORT_D = 1, and RW_READ = 1 / RW_WRITE = 0.
REQ-036 One sub-module, mem_arb_pick: combinational winner select from i_req, d_req, last-grant; contains the RR_EN variant.

Verification
REQ-037 LATENCY=2; i_req, i_address=0x80020000, m_data_out=0x27bdfff8 -> m_enable high 2 cycles, i_done in cycle t0+3, i_rdata=0x27bdfff8.
REQ-038 d write addr 0x80020100, data 0xdeadbeef -> m_rw=0, m_data_in=0xdeadbeef for 2 cycles; one d_done pulse; d_rdata unchanged.
REQ-039 i_req and d_req rise together, d re-requests right after its done -> without macro: d, d, then i; with MEM_ARBITER_RR_EN: d, i, d.
REQ-040 reset_n pulsed low in the 2nd BUSY cycle -> m_enable=0 immediately; no done pulse; rdata=0; new request after release serviced normally.
REQ-041 LATENCY=1, i_req held with new address each done -> i_done every 3 cycles, m_address tracks each registered address.
